// File: rtl/bridge_pkg.sv
// Shared opcodes, FSM state encoding and checksum constants for the UART burst bridge.
// BRIDGE_CHECKSUM_EN adds the CKSUM state used to send checksum/ack bytes.
package bridge_pkg;

  localparam logic [7:0] OP_WR   = 8'h02;
  localparam logic [7:0] OP_RD   = 8'h03;
  localparam logic [7:0] OP_BWR  = 8'h04;
  localparam logic [7:0] OP_BRD  = 8'h05;
  localparam logic [7:0] OP_HOLD = 8'h06;
  localparam logic [7:0] OP_RUN  = 8'h07;
  localparam logic [7:0] OP_FWR  = 8'h08;
  localparam logic [7:0] OP_FRD  = 8'h09;

  // XOR seed for the read checksum / write ack, and the cmd_err pulse level
  localparam logic [7:0] ACK_SEED   = 8'h00;
  localparam logic       ERR_ASSERT = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_BUS_WR, S_BUS_RD, S_TX, S_TX_WAIT
`ifdef BRIDGE_CHECKSUM_EN
    , S_CKSUM
`endif
  } bridge_state_t;

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte timeout: counts while enabled, clears on clr_i or when disabled,
// and raises tc_o for the cycle in which TIMEOUT_CYC enabled cycles have elapsed.
module bridge_timeout #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CNT_W       = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || !en_i || tc_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_burst_bridge.sv
// UART command parser driving the system bus: single/burst/fixed-address reads and writes,
// CPU hold control, inter-byte timeout. BRIDGE_CHECKSUM_EN appends a checksum/ack TX byte.
module uart_burst_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CNT_W       = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic              bus_ready,
  input  logic [7:0]        bus_rdata,
  output logic              cpu_hold,
  output logic              cmd_err
);

  localparam int AB = (ADDR_W + 7) / 8;
  localparam int BW = (AB > 1) ? $clog2(AB) : 1;

`ifdef BRIDGE_CHECKSUM_EN
  localparam bridge_state_t S_DONE = S_CKSUM;
`else
  localparam bridge_state_t S_DONE = S_IDLE;
`endif

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d, txd_q, txd_d;
  logic [8:0]        rem_q, rem_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              wr_q, wr_d, burst_q, burst_d, fixed_q, fixed_d;
  logic              hold_q, hold_d, err_q, err_d, txs_q, txs_d;
  logic              to_tc;
`ifdef BRIDGE_CHECKSUM_EN
  logic [7:0]        cks_q, cks_d;
  logic              cksent_q, cksent_d;
`endif

  bridge_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i(rx_valid),
    .en_i (state_q inside {S_ADDR, S_LEN, S_WDATA}),
    .tc_o (to_tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    rem_d   = rem_q;
    bcnt_d  = bcnt_q;
    wr_d    = wr_q;
    burst_d = burst_q;
    fixed_d = fixed_q;
    hold_d  = hold_q;
    err_d   = 1'b0;
    txs_d   = 1'b0;
`ifdef BRIDGE_CHECKSUM_EN
    cks_d    = cks_q;
    cksent_d = cksent_q;
`endif
    case (state_q)
      S_IDLE: if (rx_valid) begin
        bcnt_d = '0;
        case (rx_data)
          OP_WR, OP_RD, OP_BWR, OP_BRD, OP_FWR, OP_FRD: begin
            state_d = S_ADDR;
            wr_d    = (rx_data == OP_WR) || (rx_data == OP_BWR) || (rx_data == OP_FWR);
            burst_d = (rx_data != OP_WR) && (rx_data != OP_RD);
            fixed_d = (rx_data == OP_FWR) || (rx_data == OP_FRD);
`ifdef BRIDGE_CHECKSUM_EN
            cks_d    = ACK_SEED;
            cksent_d = 1'b0;
`endif
          end
          OP_HOLD: hold_d = 1'b1;
          OP_RUN:  hold_d = 1'b0;
          default: err_d  = ERR_ASSERT;
        endcase
      end
      S_ADDR: if (to_tc) begin
        state_d = S_IDLE;
        err_d   = ERR_ASSERT;
      end else if (rx_valid) begin
        // Shift in MSB first; truncation drops unused high bits of the first byte
        addr_d = ADDR_W'({addr_q, rx_data});
        bcnt_d = bcnt_q + BW'(1);
        if (bcnt_q == BW'(AB - 1)) begin
          rem_d   = 9'd1;
          state_d = burst_q ? S_LEN : (wr_q ? S_WDATA : S_BUS_RD);
        end
      end
      S_LEN: if (to_tc) begin
        state_d = S_IDLE;
        err_d   = ERR_ASSERT;
      end else if (rx_valid) begin
        rem_d   = {1'b0, rx_data} + 9'd1;
        state_d = wr_q ? S_WDATA : S_BUS_RD;
      end
      S_WDATA: if (to_tc) begin
        state_d = S_IDLE;
        err_d   = ERR_ASSERT;
      end else if (rx_valid) begin
        wdata_d = rx_data;
        state_d = S_BUS_WR;
`ifdef BRIDGE_CHECKSUM_EN
        cks_d = cks_q ^ rx_data;
`endif
      end
      S_BUS_WR: if (bus_ready) begin
        if (!fixed_q) addr_d = addr_q + ADDR_W'(1);
        rem_d   = rem_q - 9'd1;
        state_d = (rem_q == 9'd1) ? S_DONE : S_WDATA;
      end
      S_BUS_RD: if (bus_ready) begin
        if (!fixed_q) addr_d = addr_q + ADDR_W'(1);
        rem_d = rem_q - 9'd1;
        txd_d = bus_rdata;
`ifdef BRIDGE_CHECKSUM_EN
        cks_d = cks_q ^ bus_rdata;
`endif
        txs_d   = !tx_active;
        state_d = tx_active ? S_TX : S_TX_WAIT;
      end
      S_TX: if (!tx_active) begin
        txs_d   = 1'b1;
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: if (tx_done) begin
        state_d = (rem_q == 9'd0) ? S_DONE : S_BUS_RD;
      end
`ifdef BRIDGE_CHECKSUM_EN
      S_CKSUM: if (!cksent_q) begin
        if (!tx_active) begin
          txs_d    = 1'b1;
          txd_d    = cks_q;
          cksent_d = 1'b1;
        end
      end else if (tx_done) begin
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      rem_q   <= '0;
      bcnt_q  <= '0;
      wr_q    <= 1'b0;
      burst_q <= 1'b0;
      fixed_q <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      txs_q   <= 1'b0;
`ifdef BRIDGE_CHECKSUM_EN
      cks_q    <= '0;
      cksent_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      rem_q   <= rem_d;
      bcnt_q  <= bcnt_d;
      wr_q    <= wr_d;
      burst_q <= burst_d;
      fixed_q <= fixed_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      txs_q   <= txs_d;
`ifdef BRIDGE_CHECKSUM_EN
      cks_q    <= cks_d;
      cksent_q <= cksent_d;
`endif
    end
  end

  assign bus_we    = (state_q == S_BUS_WR);
  assign bus_re    = (state_q == S_BUS_RD);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign tx_start  = txs_q;
  assign tx_data   = txd_q;
  assign cpu_hold  = hold_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_burst_bridge.sv
// Scoreboard bench for uart_burst_bridge: directed commands push expected bus/TX/error
// events; bus, TX and error monitors pop and compare as the DUT produces them.
module tb_uart_burst_bridge;

  localparam int TO = 40;

  logic        clk = 1'b0, rst = 1'b1;
  logic        rx_valid = 1'b0, tx_active = 1'b0, tx_done = 1'b0, bus_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00, bus_rdata = 8'h00;
  logic        tx_start, bus_we, bus_re, cpu_hold, cmd_err;
  logic [7:0]  tx_data, bus_wdata;
  logic [15:0] bus_addr;

  uart_burst_bridge #(.ADDR_W(16), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .cpu_hold(cpu_hold), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [15:0] addr; logic [7:0] data;} bus_ev_t;
  bus_ev_t    exp_bus[$];
  logic [7:0] exp_tx[$];
  int         exp_err = 0;
  int         n_tests = 0, n_fail = 0;
  int         bus_dly = 0;
  logic [7:0] mem [logic [15:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic exp_w(input logic [15:0] a, input logic [7:0] d);
    bus_ev_t e;
    e.we = 1'b1; e.addr = a; e.data = d;
    exp_bus.push_back(e);
  endtask

  task automatic exp_r(input logic [15:0] a, input logic [7:0] d);
    bus_ev_t e;
    e.we = 1'b0; e.addr = a; e.data = 8'h00;
    exp_bus.push_back(e);
    exp_tx.push_back(d);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap = 10);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && (exp_bus.size() != 0 || exp_tx.size() != 0 || exp_err != 0); i++)
      @(negedge clk);
    repeat (12) @(negedge clk);
    check($sformatf("drain_%s", name), {exp_bus.size(), exp_tx.size(), exp_err}, 0);
  endtask

  // Bus slave: ready after bus_dly wait cycles, memory updated on accepted writes
  initial begin : bus_resp
    int cnt;
    bus_ev_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!(bus_we || bus_re) || rst) begin
        bus_ready = 1'b0;
        cnt = bus_dly;
      end else if (cnt > 0) begin
        bus_ready = 1'b0;
        cnt--;
      end else begin
        bus_ready = 1'b1;
        bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 8'h00;
        if (exp_bus.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_unexpected: got we=%b addr=%h, expected no transfer", bus_we, bus_addr);
        end else begin
          e = exp_bus.pop_front();
          check("bus_we", bus_we, e.we);
          check("bus_addr", bus_addr, e.addr);
          if (bus_we) begin
            check("bus_wdata", bus_wdata, e.data);
            mem[bus_addr] = bus_wdata;
          end
        end
      end
    end
  end

  // Transmitter: 6-cycle byte time, tx_data must hold until tx_done
  initial begin : tx_model
    logic [7:0] held;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        held = tx_data;
        if (exp_tx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
        end else check("tx_data", tx_data, exp_tx.pop_front());
        tx_active = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (tx_start) begin
            n_tests++; n_fail++;
            $display("FAIL tx_busy_start: got tx_start=1 while busy, expected 0");
          end
        end
        tx_active = 1'b0; tx_done = 1'b1;
        check("tx_hold", tx_data, held);
        @(negedge clk); tx_done = 1'b0;
      end
    end
  end

  initial begin : err_mon
    forever begin
      @(negedge clk);
      if (cmd_err) begin
        check("cmd_err_expected", exp_err > 0, 1'b1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33; mem[16'h4000] = 8'h5C;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, cpu_hold, cmd_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single write, zero-wait bus
    bus_dly = 0;
    exp_w(16'h8000, 8'hA5);
    send_byte(8'h02); send_byte(8'h80); send_byte(8'h00); send_byte(8'hA5);
    wait_idle("single_write");

    // incrementing burst read across the address wrap
    bus_dly = 2;
    exp_r(16'hFFFE, 8'h11); exp_r(16'hFFFF, 8'h22); exp_r(16'h0000, 8'h33);
    send_byte(8'h05); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h02);
    wait_idle("burst_read_wrap");

    // fixed-address burst write
    for (int i = 1; i <= 4; i++) exp_w(16'h2007, 8'(i));
    send_byte(8'h08); send_byte(8'h20); send_byte(8'h07); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_idle("fixed_burst_write");

    // timeout mid-address, then a normal read
    exp_err++;
    send_byte(8'h02); send_byte(8'h80, TO + 20);
    wait_idle("timeout");
    exp_r(16'h8000, 8'hA5);
    send_byte(8'h03); send_byte(8'h80); send_byte(8'h00);
    wait_idle("read_after_timeout");

    // bad opcode and hold/run
    exp_err++;
    send_byte(8'h5A);
    wait_idle("bad_opcode");
    check("hold_after_bad", cpu_hold, 1'b0);
    send_byte(8'h06);
    check("hold_set", cpu_hold, 1'b1);
    send_byte(8'h07);
    check("hold_clr", cpu_hold, 1'b0);
    send_byte(8'h06);

    // reset during the third write of an incrementing burst
    bus_dly = 3;
    exp_w(16'h1000, 8'hAA); exp_w(16'h1001, 8'hBB);
    send_byte(8'h04); send_byte(8'h10); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'hCC;
    @(negedge clk); rx_valid = 1'b0;
    check("pre_reset_we", bus_we, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_burst_reset_outputs",
          {tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, cpu_hold, cmd_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle("reset_abort");
    exp_r(16'h4000, 8'h5C);
    send_byte(8'h03); send_byte(8'h40); send_byte(8'h00);
    wait_idle("read_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_burst_bridge.md
# uart_burst_bridge

Parametrised UART-to-system-bus command bridge. Successor to the single-byte write/read/CPU-hold command parser used to load PGROM/CHROM over UART. It adds configurable address width, incrementing and fixed-address bursts (for streaming through the $2006/$2007 PPU port), an inter-byte timeout, and an optional checksum. It sits between `uart_rx`/`UART_TX` and the system-control bus arbiter in `nes_fpga_top_lvl`.

## Interface

Parameters:
- `ADDR_W`, 16: bus address width. Address is sent as `AB = ceil(ADDR_W/8)` bytes, MSB first. Unused high bits of the first byte are ignored.
- `TIMEOUT_CYC`, 2_000_000: clk cycles allowed between command bytes before abort. Minimum 16.
- `CNT_W`, 24: width of the timeout counter.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, received byte valid.
- `rx_data` in 8: received byte.
- `tx_start` out 1: one-cycle strobe to launch a TX byte.
- `tx_data` out 8: byte to transmit. Held stable from `tx_start` until `tx_done`.
- `tx_active` in 1: transmitter busy.
- `tx_done` in 1: one-cycle strobe, byte transmitted.
- `bus_addr` out ADDR_W: transaction address.
- `bus_wdata` out 8: write data.
- `bus_we` out 1: write request, held until accepted.
- `bus_re` out 1: read request, held until accepted.
- `bus_ready` in 1: accept; `bus_rdata` is valid in the same cycle for reads.
- `bus_rdata` in 8: read data.
- `cpu_hold` out 1: 1 holds the CPU/PPU in reset.
- `cmd_err` out 1: one-cycle pulse on a bad opcode or a timeout abort.

## Operation

Opcodes (first byte):
- `0x02` write: addr, data.
- `0x03` read: addr; returns 1 byte.
- `0x04` burst write, incrementing: addr, len, len+1 data bytes.
- `0x05` burst read, incrementing: addr, len; returns len+1 bytes.
- `0x08` burst write, fixed address: same format as `0x04`.
- `0x09` burst read, fixed address: same format as `0x05`.
- `0x06` set `cpu_hold`=1.
- `0x07` set `cpu_hold`=0.
- Any other opcode: ignored, `cmd_err` pulses, state stays IDLE.

State machine:
- States: IDLE, ADDR, LEN, WDATA, BUS_WR, BUS_RD, TX, TX_WAIT, CKSUM.
- IDLE -> ADDR on a valid memory opcode.
- ADDR collects AB bytes -> LEN (burst) or WDATA/BUS_RD (single).
- LEN -> WDATA (write) or BUS_RD (read).
- WDATA -> BUS_WR on each data byte.
- BUS_WR returns to WDATA while bytes remain, otherwise goes to CKSUM/IDLE.
- BUS_RD -> TX -> TX_WAIT. TX_WAIT returns to BUS_RD while bytes remain, otherwise goes to CKSUM/IDLE.

Arithmetic and boundaries:
- Burst count: len byte L gives L+1 transfers (1..256). The remaining counter is 9 bits.
- Incrementing modes add 1 after each accepted transfer, modulo 2^ADDR_W: 0xFFFF wraps to 0x0000.
- Fixed modes never change `bus_addr`.
- Timeout: the counter clears on every `rx_valid` and runs only in ADDR, LEN and WDATA. Reaching TIMEOUT_CYC returns to IDLE and pulses `cmd_err`. Bus transfers already performed are not undone.
- TX and bus wait states never time out.
- `rx_valid` arriving while not in a byte-collecting state (BUS_*, TX*) is dropped. The host must pace its bytes.

Reset values:
- All outputs 0, `cpu_hold`=0.
- State IDLE, counters 0.
- Reset mid-burst aborts immediately, with no further bus or TX activity.

## Timing

- `bus_we`/`bus_re` assert the cycle after the byte that completes the request, with `bus_addr`/`bus_wdata` stable. They deassert the cycle after `bus_ready`=1 is sampled.
- `bus_ready` may already be high in the first request cycle, giving a 1-cycle transfer.
- `bus_rdata` is captured when `bus_ready`=1.
- `tx_start` pulses the cycle after read capture, only if `tx_active`=0; otherwise it waits.
- The next bus read is issued the cycle after `tx_done`.
- Single write latency: 1 cycle from data byte to `bus_we` (plus ready wait).
- `cpu_hold` updates the cycle after the `0x06`/`0x07` byte.

## Configuration

- `BRIDGE_CHECKSUM_EN` defined:
  - After each read command, one extra byte equal to the XOR of all returned data bytes is transmitted.
  - After each write command, one ack byte equal to the XOR of all written data bytes is transmitted.
  - The CKSUM state is used.
- Undefined:
  - No checksum or ack bytes; writes produce no TX traffic.
  - CKSUM is unreachable and is removed.

## Structure

- `bridge_pkg` holds:
  - opcode localparams (OP_WR, OP_RD, OP_BWR, OP_BRD, OP_FWR, OP_FRD, OP_HOLD, OP_RUN);
  - the `bridge_state_t` enum;
  - the ack/err constants.
- Sub-module `bridge_timeout` implements the clearable/enabled counter with a terminal-count pulse, parametrised by TIMEOUT_CYC and CNT_W.

## Test plan

- `02 80 00 A5` -> one `bus_we` at 0x8000, data 0xA5, no TX (checksum off).
- `05 FF FE 02` with memory 11/22/33 at FFFE/FFFF/0000 -> `bus_re` at FFFE, FFFF, 0000 (wrap); TX 11 22 33.
- `08 20 07 03 01 02 03 04` -> four writes all at 0x2007 with data 01..04. With checksum: ack 0x04.
- `02 80` then silence for TIMEOUT_CYC -> `cmd_err` pulse, no bus activity. A following `03 80 00` is serviced normally.
- `0x5A` -> `cmd_err`, state IDLE. `06` -> `cpu_hold`=1; `07` -> `cpu_hold`=0.
- `rst` asserted during the third write of a `04` burst -> all outputs 0 next edge. A new `03` command after release works.
